// File: rtl/rv_pipe_pkg.sv
// Shared pipeline types for the EX-stage forwarding and hazard control.
package rv_pipe_pkg;

    localparam int unsigned RF_AW = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic [RF_AW-1:0] rd;
        logic             reg_write;
        logic             mem_read;
    } hz_stage_t;

    localparam logic [RF_AW-1:0] REG_X0 = '0;

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage decode info in, forwarding selects and stall/flush controls out.
interface fwd_hazard_ctrl_if
    import rv_pipe_pkg::*;
#(
    parameter int unsigned RA_W  = RF_AW,
    parameter int unsigned CNT_W = 32
) ();
    logic [RA_W-1:0]  id_rs1;
    logic [RA_W-1:0]  id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [RA_W-1:0]  id_rd;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             ex_branch_taken;
    fwd_sel_t         fwd_a_sel;
    fwd_sel_t         fwd_b_sel;
    logic             pc_write_en;
    logic             ifid_write_en;
    logic             idex_bubble;
    logic             ifid_flush;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write, id_mem_read,
               ex_branch_taken,
        input  fwd_a_sel, fwd_b_sel, pc_write_en, ifid_write_en, idex_bubble, ifid_flush,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write, id_mem_read,
               ex_branch_taken,
        output fwd_a_sel, fwd_b_sel, pc_write_en, ifid_write_en, idex_bubble, ifid_flush,
               stall_cnt, flush_cnt
    );

endinterface

// File: rtl/fwd_sel_calc.sv
// Priority compare of one source register against the two older in-flight producers.
module fwd_sel_calc
    import rv_pipe_pkg::*;
#(
    parameter int unsigned RA_W = RF_AW
) (
    input  logic [RA_W-1:0] rs,
    input  logic            use_rs,
    input  logic            near_wr,
    input  logic [RA_W-1:0] near_rd,
    input  logic            far_wr,
    input  logic [RA_W-1:0] far_rd,
    output fwd_sel_t        sel
);

    // The nearer producer reaches EX/MEM when this instruction reaches EX, so it wins.
    always_comb begin
        sel = FWD_RF;
        if (near_wr && near_rd != REG_X0 && use_rs && rs == near_rd) begin
            sel = FWD_MEM;
        end else if (far_wr && far_rd != REG_X0 && use_rs && rs == far_rd) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding select generation, load-use stall, branch flush and their perf counters.
module fwd_hazard_ctrl
    import rv_pipe_pkg::*;
#(
    parameter int unsigned RA_W  = RF_AW,
    parameter int unsigned CNT_W = 32
) (
    input logic              clk,
    input logic              rst_n,
    fwd_hazard_ctrl_if.slave bus
);

    hz_stage_t        idex_q;
    logic [RA_W-1:0]  exmem_rd_q;
    logic             exmem_wr_q;
    fwd_sel_t         fwd_a_q, fwd_b_q;
    fwd_sel_t         sel_a, sel_b;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             load_use, flush, stall, bubble;

    always_comb begin
        load_use = idex_q.mem_read && idex_q.rd != REG_X0 &&
                   ((bus.id_use_rs1 && bus.id_rs1 == idex_q.rd) ||
                    (bus.id_use_rs2 && bus.id_rs2 == idex_q.rd));
        flush    = bus.ex_branch_taken;
        stall    = load_use && !flush;
        bubble   = stall || flush;
    end

    fwd_sel_calc #(.RA_W(RA_W)) u_sel_a (
        .rs      (bus.id_rs1),
        .use_rs  (bus.id_use_rs1),
        .near_wr (idex_q.reg_write),
        .near_rd (idex_q.rd),
        .far_wr  (exmem_wr_q),
        .far_rd  (exmem_rd_q),
        .sel     (sel_a)
    );

    fwd_sel_calc #(.RA_W(RA_W)) u_sel_b (
        .rs      (bus.id_rs2),
        .use_rs  (bus.id_use_rs2),
        .near_wr (idex_q.reg_write),
        .near_rd (idex_q.rd),
        .far_wr  (exmem_wr_q),
        .far_rd  (exmem_rd_q),
        .sel     (sel_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q      <= '0;
            exmem_rd_q  <= '0;
            exmem_wr_q  <= 1'b0;
            fwd_a_q     <= FWD_RF;
            fwd_b_q     <= FWD_RF;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            exmem_rd_q <= idex_q.rd;
            exmem_wr_q <= idex_q.reg_write;
            if (bubble) begin
                idex_q  <= '0;
                fwd_a_q <= FWD_RF;
                fwd_b_q <= FWD_RF;
            end else begin
                idex_q  <= '{rd: bus.id_rd, reg_write: bus.id_reg_write,
                             mem_read: bus.id_mem_read};
                fwd_a_q <= sel_a;
                fwd_b_q <= sel_b;
            end
            if (stall && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign bus.fwd_a_sel     = fwd_a_q;
    assign bus.fwd_b_sel     = fwd_b_q;
    assign bus.pc_write_en   = !stall;
    assign bus.ifid_write_en = !stall;
    assign bus.idex_bubble   = bubble;
    assign bus.ifid_flush    = flush;
    assign bus.stall_cnt     = stall_cnt_q;
    assign bus.flush_cnt     = flush_cnt_q;

endmodule
